// File: rtl/wbq_pkg.sv
// Shared types and constants for the writeback queue: default register-file
// geometry, the queue entry layout and the pointer-width helper.
package wbq_pkg;

  localparam int unsigned WBQ_AW = 4;
  localparam int unsigned WBQ_DW = 20;

  typedef struct packed {
    logic [WBQ_AW-1:0] addr;
    logic [WBQ_DW-1:0] data;
  } wbq_entry_t;

  function automatic int unsigned wbq_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wbq_lookup.sv
// Youngest-match search over the valid queue entries for one read address.
// Purely combinational; an entry is valid when its age offset from head < count.
module wbq_lookup
  import wbq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = WBQ_AW,
  parameter int unsigned DW    = WBQ_DW,
  parameter int unsigned PW    = wbq_ptr_w(DEPTH),
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic [AW-1:0] addr_arr [DEPTH],
  input  logic [DW-1:0] data_arr [DEPTH],
  input  logic [PW-1:0] head,
  input  logic [CW-1:0] count,
  input  logic [AW-1:0] rd_addr,
  output logic          hit,
  output logic [DW-1:0] data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so later (younger) matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_arr[idx] == rd_addr)) begin
        hit  = 1'b1;
        data = data_arr[idx];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback FIFO feeding the 16 x 20-bit register file write port.
// Bypass lookup is compiled in only when WRITEBACK_QUEUE_BYPASS_EN is defined.
module writeback_queue
  import wbq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = WBQ_AW,
  parameter int unsigned DW    = WBQ_DW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain_en,
  input  logic                     flush,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            rd_addr1,
  input  logic [AW-1:0]            rd_addr2,
  output logic                     byp_hit1,
  output logic [DW-1:0]            byp_data1,
  output logic                     byp_hit2,
  output logic [DW-1:0]            byp_data2
);

  localparam int unsigned PW = wbq_ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [DW-1:0] last_data_q, last_data_d;
  logic          push, pop;

  assign in_ready = (count_q < FULL_CNT) & ~flush;
  assign rf_we    = (count_q != '0) & drain_en & ~flush & ~reset;
  assign push     = in_valid & in_ready;
  assign pop      = rf_we;
  assign count    = count_q;

  // When empty the write port shows the last popped entry, not the stale slot at head.
  assign rf_waddr = (count_q != '0) ? addr_q[head_q] : last_addr_q;
  assign rf_wdata = (count_q != '0) ? data_q[head_q] : last_data_q;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        addr_d[tail_q] = in_addr;
        data_d[tail_q] = in_data;
        tail_d         = tail_q + PW'(1);
      end
      if (pop) begin
        last_addr_d = addr_q[head_q];
        last_data_d = data_q[head_q];
        head_d      = head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  wbq_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW), .CW(CW)) u_lookup1 (
    .addr_arr (addr_q),
    .data_arr (data_q),
    .head     (head_q),
    .count    (count_q),
    .rd_addr  (rd_addr1),
    .hit      (byp_hit1),
    .data     (byp_data1)
  );

  wbq_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW), .CW(CW)) u_lookup2 (
    .addr_arr (addr_q),
    .data_arr (data_q),
    .head     (head_q),
    .count    (count_q),
    .rd_addr  (rd_addr2),
    .hit      (byp_hit2),
    .data     (byp_data2)
  );
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
  assign byp_hit1  = 1'b0;
  assign byp_data1 = '0;
  assign byp_hit2  = 1'b0;
  assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: a queue-based reference model predicts
// status and bypass outputs; a separate monitor checks every register-file write.
module tb_writeback_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [3:0]  addr;
    logic [19:0] data;
  } ent_t;

  logic        clock, reset, in_valid, in_ready, drain_en, flush, rf_we;
  logic [3:0]  in_addr, rf_waddr, rd_addr1, rd_addr2;
  logic [19:0] in_data, rf_wdata, byp_data1, byp_data2;
  logic [2:0]  count;
  logic        byp_hit1, byp_hit2;

  int   checks = 0;
  int   errors = 0;
  ent_t pending[$];
  ent_t exp_q[$];
  ent_t last_out;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .drain_en  (drain_en),
    .flush     (flush),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .count     (count),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .byp_hit1  (byp_hit1),
    .byp_data1 (byp_data1),
    .byp_hit2  (byp_hit2),
    .byp_data2 (byp_data2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every register-file write must be the oldest outstanding accepted entry.
  always @(negedge clock) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rf_we_unexpected", 32'(rf_we), 32'd0);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
        chk("rf_wdata", 32'(rf_wdata), 32'(e.data));
      end
    end
  end

  task automatic model_lookup(input logic [3:0] ra, output bit hit, output logic [19:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = pending.size() - 1; i >= 0; i--) begin
      if (pending[i].addr == ra) begin
        hit = 1'b1;
        d   = pending[i].data;
        break;
      end
    end
  endtask

  // One clock cycle: drive after posedge, check mid-cycle, then advance the model.
  task automatic cycle(input bit v, input logic [3:0] a, input logic [19:0] d,
                       input bit dr, input bit fl, input bit rs,
                       input logic [3:0] r1, input logic [3:0] r2);
    bit          exp_ready, exp_we, h1, h2;
    logic [19:0] bd1, bd2;
    ent_t        e;
    in_valid = v; in_addr = a; in_data = d; drain_en = dr; flush = fl; reset = rs;
    rd_addr1 = r1; rd_addr2 = r2;
    @(negedge clock);
    #1;
    exp_ready = (pending.size() < DEPTH) && !fl;
    exp_we    = (pending.size() != 0) && dr && !fl && !rs;
    chk("count", 32'(count), 32'(pending.size()));
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("rf_we", 32'(rf_we), 32'(exp_we));
    e = (pending.size() != 0) ? pending[0] : last_out;
    chk("port_addr", 32'(rf_waddr), 32'(e.addr));
    chk("port_data", 32'(rf_wdata), 32'(e.data));
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    model_lookup(r1, h1, bd1);
    model_lookup(r2, h2, bd2);
`else
    h1 = 1'b0; h2 = 1'b0; bd1 = '0; bd2 = '0;
`endif
    chk("byp_hit1", 32'(byp_hit1), 32'(h1));
    chk("byp_data1", 32'(byp_data1), 32'(bd1));
    chk("byp_hit2", 32'(byp_hit2), 32'(h2));
    chk("byp_data2", 32'(byp_data2), 32'(bd2));
    if (rs) begin
      pending.delete();
      exp_q.delete();
      last_out.addr = '0;
      last_out.data = '0;
    end else if (fl) begin
      pending.delete();
      exp_q.delete();
    end else begin
      if (exp_we) last_out = pending.pop_front();
      if (v && exp_ready) begin
        e.addr = a;
        e.data = d;
        pending.push_back(e);
        exp_q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    in_valid = 0; in_addr = '0; in_data = '0; drain_en = 0; flush = 0;
    rd_addr1 = '0; rd_addr2 = '0; reset = 1;
    last_out.addr = '0;
    last_out.data = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;

    // Reset state, then single push with one cycle latency
    cycle(0, 4'd0, 20'h0, 1, 0, 0, 4'd0, 4'd0);
    cycle(1, 4'd3, 20'h000AB, 1, 0, 0, 4'd3, 4'd0);
    cycle(0, 4'd0, 20'h0, 1, 0, 0, 4'd3, 4'd0);
    cycle(0, 4'd0, 20'h0, 1, 0, 0, 4'd3, 4'd0);

    // Fill with drain disabled, rejected fifth push, then drain in order
    for (int i = 1; i <= 5; i++)
      cycle(1, 4'(i), 20'(i * 17), 0, 0, 0, 4'd2, 4'd5);
    for (int i = 0; i < 5; i++)
      cycle(0, 4'd0, 20'h0, 1, 0, 0, 4'd4, 4'd1);

    // Same-address bypass: youngest wins
    cycle(1, 4'd7, 20'h00100, 0, 0, 0, 4'd7, 4'd8);
    cycle(1, 4'd7, 20'h00200, 0, 0, 0, 4'd7, 4'd8);
    cycle(0, 4'd0, 20'h0, 0, 0, 0, 4'd7, 4'd8);
    // Flush with an offered push
    cycle(1, 4'd9, 20'h00999, 1, 1, 0, 4'd7, 4'd9);
    cycle(0, 4'd0, 20'h0, 1, 0, 0, 4'd7, 4'd9);
    cycle(0, 4'd0, 20'h0, 1, 0, 0, 4'd7, 4'd9);

    // Reset mid-operation discards three queued entries
    for (int i = 0; i < 3; i++)
      cycle(1, 4'(10 + i), 20'(20'hA0000 + i), 0, 0, 0, 4'd10, 4'd11);
    cycle(0, 4'd0, 20'h0, 1, 0, 1, 4'd10, 4'd11);
    cycle(0, 4'd0, 20'h0, 1, 0, 0, 4'd10, 4'd11);
    cycle(0, 4'd0, 20'h0, 1, 0, 0, 4'd10, 4'd11);

    // Continuous push with drain across pointer wrap, including register 0
    for (int i = 0; i < 3 * DEPTH; i++)
      cycle(1, 4'(i), 20'(20'h30000 + i * 3), 1, 0, 0, 4'(i), 4'(i + 1));

    // Randomized phase
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), 20'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 59) == 0,
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 2 * DEPTH; i++)
      cycle(0, 4'd0, 20'h0, 1, 0, 0, 4'd0, 4'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
